axi_lite_rr_arbiter: RTL

Two-requester arbiter and sequencer in front of one AXI4-Lite master port. Each requester issues single-beat read or write commands on a simple valid/ready command interface. The block picks a winner round-robin, drives the full AXI4-Lite handshake sequence (AW+W→B or AR→R) and returns the response to the winner. It sits between internal clients (e.g. a DMA descriptor fetcher and a CPU bridge) and the shared register-bus master port.

---
 rtl/axi_lite_rr_arbiter_if.sv | 43 ++++
 rtl/axi_lite_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter_if.sv
// axi_lite_rr_arbiter_if
//   AXI4-Lite bus bundle between the arbiter (master modport) and the shared
//   register-bus slave (slave modport).
//   Channels: AW (VALID/READY/ADDR/PROT), W (VALID/READY/DATA/STRB),
//             B (VALID/READY/RESP), AR (VALID/READY/ADDR/PROT),
//             R (VALID/READY/DATA/RESP).
//   Parameters: ADDR_WIDTH, DATA_WIDTH (strobe width DATA_WIDTH/8).
interface axi_lite_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter
//   Two-requester arbiter/sequencer in front of one AXI4-Lite master port.
//   One outstanding transaction; winner chosen round-robin (requester 0 wins
//   the first contention after reset). Build option AXIL_ARB_FIXED_PRIO_EN:
//   requester 0 always wins contention, no last-grant state.
//   Ports:
//     ACLK, ARESETn           clock, asynchronous active-low reset
//     req_valid/req_write     per-requester command valid / write flag
//     req_addr/wdata/wstrb    packed per-requester command payload
//     req_ready               one-cycle accept pulse to the granted requester
//     rsp_valid               one-cycle response pulse to the owner
//     rsp_rdata/rsp_resp      shared response payload, qualified by rsp_valid
//     axi                     AXI4-Lite master port (interface, master modport)
//   Cycle sequence per transaction: IDLE (arbitrate), grant (req_ready),
//   AW+W or AR issue, B or R, DONE (rsp_valid).
module axi_lite_rr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  axi_lite_rr_arbiter_if.master     axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;

  state_t                  state;
  logic                    owner;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [STRB_WIDTH-1:0]   cmd_wstrb;
  logic                    aw_done;
  logic                    w_done;

  logic                    winner;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [STRB_WIDTH-1:0]   sel_wstrb;
  logic                    aw_fire;
  logic                    w_fire;

`ifndef AXIL_ARB_FIXED_PRIO_EN
  logic                    last_grant;
`endif

  always_comb begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
    winner = !req_valid[0];
`else
    // Contention goes to the requester not granted last; otherwise the lone
    // valid requester (req_valid[1] alone selects requester 1).
    winner = (req_valid == 2'b11) ? !last_grant : req_valid[1];
`endif
    sel_write = winner ? req_write[1] : req_write[0];
    sel_addr  = winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    sel_wstrb = winner ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
  end

  assign aw_fire = axi.AWVALID && axi.AWREADY;
  assign w_fire  = axi.WVALID && axi.WREADY;

  // Address/data outputs come straight from the command latches, which only
  // change at grant time, so they are stable for the whole VALID window.
  assign axi.AWADDR = cmd_addr;
  assign axi.ARADDR = cmd_addr;
  assign axi.WDATA  = cmd_wdata;
  assign axi.WSTRB  = cmd_wstrb;
  assign axi.AWPROT = '0;
  assign axi.ARPROT = '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_wstrb   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      axi.AWVALID <= 1'b0;
      axi.WVALID  <= 1'b0;
      axi.BREADY  <= 1'b0;
      axi.ARVALID <= 1'b0;
      axi.RREADY  <= 1'b0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= winner;
            req_ready <= {winner, !winner};
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_wstrb <= sel_wstrb;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            last_grant <= winner;
`endif
            state     <= sel_write ? WR_REQ : RD_REQ;
          end
        end

        // The first cycle in WR_REQ/RD_REQ is the grant cycle (req_ready
        // high); the AXI request is raised at its end.
        WR_REQ: begin
          if (|req_ready) begin
            req_ready   <= '0;
            axi.AWVALID <= 1'b1;
            axi.WVALID  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
          end else begin
            if (aw_fire) begin
              axi.AWVALID <= 1'b0;
              aw_done     <= 1'b1;
            end
            if (w_fire) begin
              axi.WVALID <= 1'b0;
              w_done     <= 1'b1;
            end
            if ((aw_done || aw_fire) && (w_done || w_fire)) begin
              axi.BREADY <= 1'b1;
              state      <= WR_RESP;
            end
          end
        end

        WR_RESP: begin
          if (axi.BVALID) begin
            axi.BREADY <= 1'b0;
            rsp_resp   <= axi.BRESP;
            rsp_rdata  <= '0;
            rsp_valid  <= {owner, !owner};
            state      <= DONE;
          end
        end

        RD_REQ: begin
          if (|req_ready) begin
            req_ready   <= '0;
            axi.ARVALID <= 1'b1;
          end else if (axi.ARREADY) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
            state       <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (axi.RVALID) begin
            axi.RREADY <= 1'b0;
            rsp_resp   <= axi.RRESP;
            rsp_rdata  <= axi.RDATA;
            rsp_valid  <= {owner, !owner};
            state      <= DONE;
          end
        end

        DONE: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
